// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the add-shift signed multiplier.
//
// Contents:
//   MULT_WIDTH : operand width, shared with the datapath top.
//   CNT_W      : iteration counter width for MULT_WIDTH.
//   state_t    : control FSM states (CLRA is only reachable when the
//                MULT_CTRL_AUTO_CLEAR_EN build macro is defined).
package mult_pkg;

  localparam int MULT_WIDTH = 8;
  localparam int CNT_W      = $clog2(MULT_WIDTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLRA  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/mult_ctrl.sv
// mult_ctrl: control unit for the add-shift signed multiplier.
//
// Sequences clear/load, conditional add (subtract on the last iteration)
// and arithmetic right shift over WIDTH iterations from one Run request.
// Only the multiplier LSB (M = B[0]) is visible here; operand values never are.
//
// Build macro: MULT_CTRL_AUTO_CLEAR_EN
//   defined   : IDLE + Run passes through a one-cycle CLRA state that pulses
//               ClrA_Only (clear A and X, keep B); latency 2*WIDTH+1.
//   undefined : no CLRA, no ClrA_Only port; A keeps the previous high byte
//               so consecutive runs accumulate. Latency 2*WIDTH.
//
// Ports:
//   Clk          in   system clock
//   Reset_n      in   asynchronous active-low reset
//   Run          in   start request (debounced level)
//   ClearA_LoadB in   clear A/X and load B from switches (IDLE only)
//   M            in   current multiplier LSB
//   Clr_Ld       out  clear A and X, load B with switch value
//   Ld_A         out  load A with adder result
//   Ld_X         out  load X with adder sign bit
//   Fn           out  adder function, 0 = add, 1 = subtract
//   Shift_En     out  shift X -> A -> B right by one
//   Busy         out  high in CLRA/ADD/SHIFT
//   Done         out  high in HOLD
//   ClrA_Only    out  clear A and X only (macro builds only)
//   dbg_state    out  current FSM state, for observation
//   dbg_cnt      out  current iteration count, for observation
//
// Handshake: Run is a level request. It is accepted on the first rising edge
// seen in IDLE; after that it is ignored until HOLD, which is left on the
// first edge with Run low, so holding Run high never auto-restarts.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       Run,
  input  logic                       ClearA_LoadB,
  input  logic                       M,
  output logic                       Clr_Ld,
  output logic                       Ld_A,
  output logic                       Ld_X,
  output logic                       Fn,
  output logic                       Shift_En,
  output logic                       Busy,
  output logic                       Done,
`ifdef MULT_CTRL_AUTO_CLEAR_EN
  output logic                       ClrA_Only,
`endif
  output state_t                     dbg_state,
  output logic [$clog2(WIDTH)-1:0]   dbg_cnt
);

  localparam int CW = $clog2(WIDTH);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last;

  assign last      = (cnt == CW'(WIDTH - 1));
  assign dbg_state = state;
  assign dbg_cnt   = cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    Clr_Ld    = 1'b0;
    Ld_A      = 1'b0;
    Ld_X      = 1'b0;
    Fn        = 1'b0;
    Shift_En  = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
`ifdef MULT_CTRL_AUTO_CLEAR_EN
    ClrA_Only = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        // Run wins over a simultaneous clear/load press.
        Clr_Ld = ClearA_LoadB & ~Run;
        if (Run) begin
          cnt_nxt   = '0;
`ifdef MULT_CTRL_AUTO_CLEAR_EN
          state_nxt = CLRA;
`else
          state_nxt = ADD;
`endif
        end
      end
      CLRA: begin
        Busy      = 1'b1;
`ifdef MULT_CTRL_AUTO_CLEAR_EN
        ClrA_Only = 1'b1;
`endif
        state_nxt = ADD;
      end
      ADD: begin
        // M=0 still spends the cycle here so latency is data-independent.
        // Subtract only on the sign-bit iteration, and only with a load, so
        // Fn is never asserted without Ld_A.
        Busy      = 1'b1;
        Ld_A      = M;
        Ld_X      = M;
        Fn        = M & last;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        Busy     = 1'b1;
        Shift_En = 1'b1;
        // Exit before incrementing so cnt never wraps.
        if (last) begin
          state_nxt = HOLD;
        end else begin
          cnt_nxt   = cnt + CW'(1);
          state_nxt = ADD;
        end
      end
      HOLD: begin
        Done = 1'b1;
        if (!Run) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl: self-checking bench for mult_ctrl with a behavioural
// datapath (A, B, X, 9-bit add/sub) driven by the DUT strobes.
// Inputs are driven at the falling edge; outputs are sampled 1 ns later.
// Build macro MULT_CTRL_AUTO_CLEAR_EN selects the CLRA variant.
module tb_mult_ctrl;
  import mult_pkg::*;

  localparam int W = MULT_WIDTH;
`ifdef MULT_CTRL_AUTO_CLEAR_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 0;
`endif

  // Output vector bit weights: {clra, Clr_Ld, Ld_A, Ld_X, Fn, Shift_En, Busy, Done}
  localparam logic [7:0] OB_CLRA = 8'h80;
  localparam logic [7:0] OB_CLR  = 8'h40;
  localparam logic [7:0] OB_LDA  = 8'h20;
  localparam logic [7:0] OB_LDX  = 8'h10;
  localparam logic [7:0] OB_FN   = 8'h08;
  localparam logic [7:0] OB_SH   = 8'h04;
  localparam logic [7:0] OB_BUSY = 8'h02;
  localparam logic [7:0] OB_DONE = 8'h01;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic Run = 1'b0;
  logic ClearA_LoadB = 1'b0;
  logic M;
  logic Clr_Ld, Ld_A, Ld_X, Fn, Shift_En, Busy, Done, clra;
  state_t dbg_state;
  logic [$clog2(W)-1:0] dbg_cnt;

  logic [7:0] sw = 8'h00;
  logic [7:0] dp_a = 8'h00;
  logic [7:0] dp_b = 8'h00;
  logic       dp_x = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- DUT ----------------
  mult_ctrl #(.WIDTH(W)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .M            (M),
    .Clr_Ld       (Clr_Ld),
    .Ld_A         (Ld_A),
    .Ld_X         (Ld_X),
    .Fn           (Fn),
    .Shift_En     (Shift_En),
    .Busy         (Busy),
    .Done         (Done),
`ifdef MULT_CTRL_AUTO_CLEAR_EN
    .ClrA_Only    (clra),
`endif
    .dbg_state    (dbg_state),
    .dbg_cnt      (dbg_cnt)
  );
`ifndef MULT_CTRL_AUTO_CLEAR_EN
  assign clra = 1'b0;
`endif

  // ---------------- datapath model ----------------
  assign M = dp_b[0];

  always @(posedge Clk) begin
    logic [8:0] sum;
    if (Clr_Ld) begin
      dp_a <= 8'h00;
      dp_x <= 1'b0;
      dp_b <= sw;
    end else if (clra) begin
      dp_a <= 8'h00;
      dp_x <= 1'b0;
    end else if (Ld_A) begin
      sum = Fn ? ({dp_a[7], dp_a} - {sw[7], sw}) : ({dp_a[7], dp_a} + {sw[7], sw});
      dp_a <= sum[7:0];
      if (Ld_X) dp_x <= sum[8];
    end else if (Shift_En) begin
      dp_b <= {dp_a[0], dp_b[7:1]};
      dp_a <= {dp_x, dp_a[7:1]};
    end
  end

  // ---------------- checking helpers ----------------
  function automatic logic [7:0] outs();
    return {clra, Clr_Ld, Ld_A, Ld_X, Fn, Shift_En, Busy, Done};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Strobe exclusivity checked on every cycle out of reset.
  always @(negedge Clk) begin
    #2;
    if (Reset_n) begin
      n_checks++;
      if ((Shift_En && (Ld_A || Clr_Ld || clra)) || (Fn && !Ld_A)) begin
        n_fail++;
        $display("FAIL invariant: outs=0x%0h (t=%0t)", outs(), $time);
      end
    end
  end

  // Expected output vector for compute cycle c (1 = first cycle after accept),
  // derived from the iteration schedule: optional clear slot, then W pairs of
  // (add slot, shift slot). Add slot k sees multiplier bit k.
  function automatic logic [7:0] expect_cycle(input int c, input logic [7:0] b);
    int p, k;
    if (OFF == 1 && c == 1) return OB_CLRA | OB_BUSY;
    p = c - OFF;
    if (p % 2 == 1) begin
      k = (p - 1) / 2;
      if (b[k]) return OB_BUSY | OB_LDA | OB_LDX | ((k == W - 1) ? OB_FN : 8'h00);
      return OB_BUSY;
    end
    return OB_BUSY | OB_SH;
  endfunction

  // One complete multiply. load: press ClearA_LoadB with b_in first.
  // combo: assert ClearA_LoadB together with Run at accept.
  // hold: extra HOLD cycles with Run held high. drop_run: release Run mid-run.
  // noise: toggle ClearA_LoadB randomly while busy and in HOLD.
  task automatic do_mult(input logic [7:0] s, input logic [7:0] b_in, input bit load,
                         input bit combo, input int hold, input bit drop_run, input bit noise,
                         input string tag);
    logic [7:0] b;
    logic [15:0] prod;
    int sa, sb;
    if (load) begin
      @(negedge Clk); sw = b_in; Run = 1'b0; ClearA_LoadB = 1'b1; #1;
      check({tag, "_load"}, outs(), OB_CLR);
    end
    @(negedge Clk); sw = s; Run = 1'b1; ClearA_LoadB = combo; #1;
    check({tag, "_accept"}, outs(), 8'h00);
    b = load ? b_in : dp_b;
    sa = $signed(s);
    sb = $signed(b);
    prod = 16'(sa * sb);
    for (int c = 1; c <= 2 * W + OFF; c++) begin
      @(negedge Clk);
      if (drop_run && c > 2) Run = 1'b0;
      ClearA_LoadB = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      check($sformatf("%s_cyc%0d", tag, c), outs(), expect_cycle(c, b));
    end
    @(negedge Clk); ClearA_LoadB = noise ? 1'($urandom_range(0, 1)) : 1'b0; #1;
    check({tag, "_hold"}, outs(), OB_DONE);
    check({tag, "_product"}, {dp_a, dp_b}, prod);
    if (!drop_run) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge Clk); ClearA_LoadB = noise ? 1'($urandom_range(0, 1)) : 1'b0; #1;
        check($sformatf("%s_hold%0d", tag, h), outs(), OB_DONE);
      end
      @(negedge Clk); Run = 1'b0; ClearA_LoadB = 1'b0; #1;
      check({tag, "_hold_exit"}, outs(), OB_DONE);
    end
    @(negedge Clk); Run = 1'b0; ClearA_LoadB = 1'b0; #1;
    check({tag, "_idle"}, outs(), 8'h00);
    check({tag, "_idle_state"}, dbg_state, IDLE);
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic       run;
    logic       clb;
    logic [7:0] exp;
  } idle_vec_t;

  typedef struct {
    logic [7:0] s;
    logic [7:0] b;
  } mul_vec_t;

  idle_vec_t idle_tab[4];
  mul_vec_t  mul_tab[8];

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    idle_tab[0] = '{1'b0, 1'b0, 8'h00};
    idle_tab[1] = '{1'b0, 1'b1, OB_CLR};
    idle_tab[2] = '{1'b1, 1'b0, 8'h00};
    idle_tab[3] = '{1'b1, 1'b1, 8'h00};

    mul_tab[0] = '{8'h07, 8'h03};
    mul_tab[1] = '{8'h03, 8'h80};
    mul_tab[2] = '{8'hFF, 8'hFF};
    mul_tab[3] = '{8'h80, 8'h80};
    mul_tab[4] = '{8'h7F, 8'h81};
    mul_tab[5] = '{8'h00, 8'h55};
    mul_tab[6] = '{8'h01, 8'h01};
    mul_tab[7] = '{8'h80, 8'h7F};

    // Reset state, including Clr_Ld following the button during reset.
    #3;
    check("rst_outs", outs(), 8'h00);
    check("rst_state", dbg_state, IDLE);
    check("rst_cnt", dbg_cnt, 0);
    ClearA_LoadB = 1'b1; #1;
    check("rst_clr_ld", outs(), OB_CLR);
    ClearA_LoadB = 1'b0;
    @(negedge Clk); Reset_n = 1'b1;

    // IDLE combinational decode; inputs withdrawn before the next edge.
    foreach (idle_tab[i]) begin
      @(negedge Clk); Run = idle_tab[i].run; ClearA_LoadB = idle_tab[i].clb; #1;
      check($sformatf("idle_tab%0d", i), outs(), idle_tab[i].exp);
      #1; Run = 1'b0; ClearA_LoadB = 1'b0;
    end

    // Table of operand pairs, each loaded then multiplied.
    foreach (mul_tab[i])
      do_mult(mul_tab[i].s, mul_tab[i].b, 1'b1, 1'b0, 0, 1'b0, 1'b0, $sformatf("tab%0d", i));

    // Clr_Ld follows a 3-cycle press exactly, then Run beats the button.
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk); sw = 8'h05; Run = 1'b0; ClearA_LoadB = 1'b1; #1;
      check($sformatf("press%0d", i), outs(), OB_CLR);
    end
    @(negedge Clk); ClearA_LoadB = 1'b0; #1;
    check("press_release", outs(), 8'h00);
    do_mult(8'h06, 8'h05, 1'b0, 1'b1, 0, 1'b0, 1'b0, "combo");

    // Run held through HOLD for 10 cycles, then a fresh run.
    do_mult(8'h09, 8'hF3, 1'b1, 1'b0, 10, 1'b0, 1'b0, "hold10");
    do_mult(8'hC5, 8'h2B, 1'b1, 1'b0, 0, 1'b0, 1'b1, "restart");

    // Reset mid-operation at cnt=3 in ADD.
    @(negedge Clk); sw = 8'h3C; Run = 1'b0; ClearA_LoadB = 1'b1;
    @(negedge Clk); sw = 8'h11; ClearA_LoadB = 1'b0; Run = 1'b1;
    for (int c = 1; c <= 7 + OFF; c++) @(negedge Clk);
    #1;
    check("pre_rst_cnt", dbg_cnt, 3);
    check("pre_rst_state", dbg_state, ADD);
    Reset_n = 1'b0; #1;
    check("mid_rst_outs", outs(), 8'h00);
    check("mid_rst_state", dbg_state, IDLE);
    check("mid_rst_cnt", dbg_cnt, 0);
    Run = 1'b0;
    @(negedge Clk); Reset_n = 1'b1;
    do_mult(8'hE7, 8'h64, 1'b1, 1'b0, 2, 1'b0, 1'b0, "after_rst");

`ifdef MULT_CTRL_AUTO_CLEAR_EN
    // Back-to-back runs without a press: CLRA zeroes A, B carries over.
    do_mult(8'h02, 8'h02, 1'b1, 1'b0, 0, 1'b0, 1'b0, "auto1");
    do_mult(8'h02, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0, "auto2");
    dp_a = 8'hA5;
    do_mult(8'hFD, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0, "auto3");
`endif

    // Randomized runs against the arithmetic product.
    for (int i = 0; i < 12; i++) begin
      do_mult(8'($urandom), 8'($urandom), 1'b1, 1'b0, $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    #20;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
